// File: rtl/soc_system_b2p_pkg.sv
// Shared constants and types for the byte-to-packet converter.
package soc_system_b2p_pkg;

  // Default in-band control characters
  localparam logic [7:0] SOP_CHAR_DEFAULT  = 8'h7A;
  localparam logic [7:0] EOP_CHAR_DEFAULT  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR_DEFAULT = 8'h7C;
  localparam logic [7:0] ESC_CHAR_DEFAULT  = 8'h7D;

  // An escaped byte is recovered by XORing it with this mask
  localparam logic [7:0] ESC_XOR = 8'h20;

  // Decoder state: what the next accepted byte means
  typedef enum logic [1:0] {
    StNormal  = 2'd0,
    StEsc     = 2'd1,
    StChan    = 2'd2,
    StChanEsc = 2'd3
  } b2p_state_e;

endpackage

// File: rtl/soc_system_st_out_reg.sv
// Single-entry streaming output register. Accepts a new beat whenever the
// held one is being drained or none is held, giving full throughput.
module soc_system_st_out_reg #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = out_ready || !valid_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load on a new beat, otherwise drop the held beat once it is taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/soc_system_master_secure_bytes_to_packets.sv
// Byte stream to Avalon-ST packet converter. Decodes SOP/EOP/channel markers
// and escapes, emitting one registered beat per payload byte.
// Optional protocol-error output enabled by SOC_SYSTEM_B2P_PROTO_ERR_EN.
module soc_system_master_secure_bytes_to_packets
  import soc_system_b2p_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter logic [7:0]  SOP_CHAR      = SOP_CHAR_DEFAULT,
  parameter logic [7:0]  EOP_CHAR      = EOP_CHAR_DEFAULT,
  parameter logic [7:0]  CHAN_CHAR     = CHAN_CHAR_DEFAULT,
  parameter logic [7:0]  ESC_CHAR      = ESC_CHAR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
`ifdef SOC_SYSTEM_B2P_PROTO_ERR_EN
  ,
  output logic                     proto_err
`endif
);

  localparam int unsigned PayloadWidth = 8 + CHANNEL_WIDTH + 2;

  b2p_state_e               state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic                     sop_pend_q, sop_pend_d;
  logic                     eop_pend_q, eop_pend_d;
  logic                     accept;
  logic                     emit;
  logic [7:0]               emit_byte;
  logic [7:0]               unesc;
  logic [PayloadWidth-1:0]  beat;
  logic [PayloadWidth-1:0]  held;

  assign accept = in_valid && in_ready;
  assign unesc  = in_data ^ ESC_XOR;

  // Decoder state, channel and pending-flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StNormal;
      chan_q     <= '0;
      sop_pend_q <= 1'b0;
      eop_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      sop_pend_q <= sop_pend_d;
      eop_pend_q <= eop_pend_d;
    end
  end

  // Byte decode: next state, channel update, pending flags and payload emit
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    sop_pend_d = sop_pend_q;
    eop_pend_d = eop_pend_q;
    emit       = 1'b0;
    emit_byte  = in_data;
    if (accept) begin
      unique case (state_q)
        StNormal: begin
          if (in_data == SOP_CHAR) begin
            sop_pend_d = 1'b1;
          end else if (in_data == EOP_CHAR) begin
            eop_pend_d = 1'b1;
          end else if (in_data == CHAN_CHAR) begin
            state_d = StChan;
          end else if (in_data == ESC_CHAR) begin
            state_d = StEsc;
          end else begin
            emit = 1'b1;
          end
        end
        StEsc: begin
          emit      = 1'b1;
          emit_byte = unesc;
          state_d   = StNormal;
        end
        StChan: begin
          // Markers seen while awaiting the channel byte keep us waiting for it
          if (in_data == ESC_CHAR) begin
            state_d = StChanEsc;
          end else if (in_data == SOP_CHAR) begin
            sop_pend_d = 1'b1;
          end else if (in_data == EOP_CHAR) begin
            eop_pend_d = 1'b1;
          end else if (in_data == CHAN_CHAR) begin
            state_d = StChan;
          end else begin
            chan_d  = in_data[CHANNEL_WIDTH-1:0];
            state_d = StNormal;
          end
        end
        StChanEsc: begin
          chan_d  = unesc[CHANNEL_WIDTH-1:0];
          state_d = StNormal;
        end
        default: state_d = StNormal;
      endcase
    end
    if (emit) begin
      sop_pend_d = 1'b0;
      eop_pend_d = 1'b0;
    end
  end

  assign beat = {emit_byte, chan_q, sop_pend_q, eop_pend_q};

  soc_system_st_out_reg #(
    .WIDTH(PayloadWidth)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (emit),
    .load_data (beat),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (held)
  );

  assign out_data          = held[PayloadWidth-1 -: 8];
  assign out_channel       = held[CHANNEL_WIDTH+1:2];
  assign out_startofpacket = held[1];
  assign out_endofpacket   = held[0];

`ifdef SOC_SYSTEM_B2P_PROTO_ERR_EN
  logic in_packet_q;
  logic proto_err_q;

  assign proto_err = proto_err_q;

  // Track packet framing and flag payload outside a packet or a nested SOP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_packet_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= emit && (sop_pend_q == in_packet_q);
      if (emit) begin
        if (eop_pend_q) begin
          in_packet_q <= 1'b0;
        end else if (sop_pend_q) begin
          in_packet_q <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_soc_system_master_secure_bytes_to_packets.sv
// Self-checking bench for the byte-to-packet converter. A byte-level model of
// the framing rules predicts every beat; directed sequences pin literal values.
module tb_soc_system_master_secure_bytes_to_packets;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [CW-1:0] out_channel;
  logic          out_startofpacket;
  logic          out_endofpacket;
`ifdef SOC_SYSTEM_B2P_PROTO_ERR_EN
  logic          proto_err;
`endif

  soc_system_master_secure_bytes_to_packets #(
    .CHANNEL_WIDTH(CW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket)
`ifdef SOC_SYSTEM_B2P_PROTO_ERR_EN
    ,
    .proto_err         (proto_err)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]    d;
    logic [CW-1:0] ch;
    logic          sop;
    logic          eop;
    logic          err;
  } beat_t;

  beat_t        exp_q[$];
  logic [17:0]  log_q[$];
  bit           fresh;
  bit           prev_hold;
  logic [17:0]  prev_beat;

  // Model of the framing rules, operating on whole accepted bytes
  bit            m_esc, m_chan, m_chan_esc, m_sop, m_eop, m_inpkt;
  logic [CW-1:0] m_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_esc = 0; m_chan = 0; m_chan_esc = 0; m_sop = 0; m_eop = 0; m_inpkt = 0;
    m_ch = '0;
  endfunction

  function automatic void model_emit(input logic [7:0] d);
    beat_t b;
    b.d   = d;
    b.ch  = m_ch;
    b.sop = m_sop;
    b.eop = m_eop;
    b.err = (!m_sop && !m_inpkt) || (m_sop && m_inpkt);
    exp_q.push_back(b);
    fresh = 1;
    if (m_eop) m_inpkt = 0;
    else if (m_sop) m_inpkt = 1;
    m_sop = 0;
    m_eop = 0;
  endfunction

  function automatic void model_feed(input logic [7:0] b);
    logic [7:0] u;
    u = b ^ 8'h20;
    if (m_esc) begin
      m_esc = 0;
      model_emit(u);
    end else if (m_chan_esc) begin
      m_chan_esc = 0;
      m_ch = u[CW-1:0];
    end else if (m_chan) begin
      if (b == 8'h7D) begin m_chan = 0; m_chan_esc = 1; end
      else if (b == 8'h7A) m_sop = 1;
      else if (b == 8'h7B) m_eop = 1;
      else if (b != 8'h7C) begin m_chan = 0; m_ch = b[CW-1:0]; end
    end else begin
      if (b == 8'h7A) m_sop = 1;
      else if (b == 8'h7B) m_eop = 1;
      else if (b == 8'h7C) m_chan = 1;
      else if (b == 8'h7D) m_esc = 1;
      else model_emit(b);
    end
  endfunction

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin
    logic [17:0] cur;
    cur = {out_data, out_channel, out_startofpacket, out_endofpacket};
    if (!reset_n) begin
      model_reset();
      exp_q.delete();
      prev_hold = 0;
      fresh = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(out_ready || !out_valid));
      if (out_valid && exp_q.size() != 0) begin
        chk("beat", 32'(cur), 32'({exp_q[0].d, exp_q[0].ch, exp_q[0].sop, exp_q[0].eop}));
        if (prev_hold) chk("hold_stable", 32'(cur), 32'(prev_beat));
      end
`ifdef SOC_SYSTEM_B2P_PROTO_ERR_EN
      chk("proto_err", 32'(proto_err),
          32'((exp_q.size() != 0 && fresh) ? exp_q[0].err : 1'b0));
`endif
      fresh = 0;
      prev_hold = out_valid && !out_ready;
      prev_beat = cur;
      if (out_valid && out_ready && exp_q.size() != 0) begin
        log_q.push_back(cur);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) model_feed(in_data);
    end
  end

  // Present one byte and hold it until accepted (bounded wait)
  task automatic send(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [17:0] v);
    chk(name, (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hDEAD_BEEF, 32'(v));
  endtask

  initial begin
    int base;
    model_reset();
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fields", 32'({out_data, out_channel, out_startofpacket, out_endofpacket}), 32'd0);
    #14 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Channel 5 packet of three bytes
    base = log_q.size();
    send(8'h7A); send(8'h7C); send(8'h05); send(8'h11);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    chk("t1_latency_data", 32'(out_data), 32'h11);
    send(8'h22); send(8'h7B); send(8'h33);
    idle(3);
    chk_log("t1_beat0", base + 0, {8'h11, 8'h05, 1'b1, 1'b0});
    chk_log("t1_beat1", base + 1, {8'h22, 8'h05, 1'b0, 1'b0});
    chk_log("t1_beat2", base + 2, {8'h33, 8'h05, 1'b0, 1'b1});

    // Escaped SOP char as a single-beat packet
    base = log_q.size();
    send(8'h7A); send(8'h7B); send(8'h7D); send(8'h5A);
    idle(3);
    chk_log("t2_single", base, {8'h7A, 8'h05, 1'b1, 1'b1});

    // Escaped channel byte
    base = log_q.size();
    send(8'h7C); send(8'h7D); send(8'h5C); send(8'h7A); send(8'h7B); send(8'h41);
    idle(3);
    chk_log("t3_esc_chan", base, {8'h41, 8'h7C, 1'b1, 1'b1});

    // Backpressure: hold a beat for five cycles, then drain and accept together
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h60;
    @(posedge clk);
    #1;
    in_data = 8'h61;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_data", 32'(out_data), 32'h60);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_next_valid", 32'(out_valid), 32'd1);
    chk("release_next_data", 32'(out_data), 32'h61);
    @(posedge clk);
    #1;
    idle(2);

    // Reset mid-packet
    send(8'h7A); send(8'h7C); send(8'h03);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_fields",
        32'({out_data, out_channel, out_startofpacket, out_endofpacket}), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    base = log_q.size();
    send(8'h44);
    idle(3);
    chk_log("postrst_beat", base, {8'h44, 8'h00, 1'b0, 1'b0});

`ifdef SOC_SYSTEM_B2P_PROTO_ERR_EN
    send(8'h55);
    chk("perr_orphan", 32'(proto_err), 32'd1);
    idle(1);
    chk("perr_pulse_end", 32'(proto_err), 32'd0);
    send(8'h7A); send(8'h7B); send(8'h66);
    chk("perr_clean", 32'(proto_err), 32'd0);
    chk("perr_clean_data", 32'(out_data), 32'h66);
    idle(3);
`endif

    chk("model_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc_system_master_secure_bytes_to_packets.md
Name: soc_system_master_secure_bytes_to_packets

Overview:
Converts the raw byte stream from the JTAG/host byte channel into Avalon-ST packets carrying channel, SOP and EOP sideband. It decodes in-band control characters and escapes, then presents one registered data beat per payload byte. It sits directly upstream of the master's channel adapter, which consumes out_channel/out_startofpacket/out_endofpacket.

Parameters:
CHANNEL_WIDTH, 8, width of out_channel; the channel byte is truncated to this width (1..8).
SOP_CHAR, 8'h7A, start-of-packet marker.
EOP_CHAR, 8'h7B, end-of-packet marker.
CHAN_CHAR, 8'h7C, channel marker; the next decoded byte is the channel.
ESC_CHAR, 8'h7D, escape; the next byte is XORed with 8'h20.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in_ready  output  1  byte accepted when in_valid && in_ready
in_valid  input  1  input byte valid
in_data  input  8  raw byte
out_ready  input  1  downstream ready
out_valid  output  1  output beat valid
out_data  output  8  decoded payload byte
out_channel  output  CHANNEL_WIDTH  current channel
out_startofpacket  output  1  first beat of packet
out_endofpacket  output  1  last beat of packet

Behaviour:
- Reset (async assert, sync deassert is the reset source's responsibility): out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0, state=NORMAL, sop_pend=0, eop_pend=0.
- in_ready = out_ready || !out_valid (combinational). This gives full throughput with a single output register.
- Output register: it loads when a payload byte is accepted. Otherwise out_valid clears when out_ready is high. Latency is 1 cycle from the accepted payload byte to out_valid. Outputs hold stable while out_valid && !out_ready.
- FSM states: NORMAL, ESC, CHAN, CHAN_ESC. Transitions happen only on an accepted byte.
- NORMAL:
  - SOP_CHAR: sop_pend=1.
  - EOP_CHAR: eop_pend=1.
  - CHAN_CHAR: go to CHAN.
  - ESC_CHAR: go to ESC.
  - Any other byte: emit it as payload.
- ESC: emit (byte ^ 8'h20) as payload; go to NORMAL. This applies even if the byte is a control char.
- CHAN:
  - ESC_CHAR: go to CHAN_ESC.
  - SOP/EOP/CHAN_CHAR: process as in NORMAL; the channel is unchanged.
  - Any other byte: channel register = byte[CHANNEL_WIDTH-1:0]; go to NORMAL.
- CHAN_ESC: channel register = (byte ^ 8'h20) truncated; go to NORMAL.
- Payload emit:
  - out_startofpacket=sop_pend, out_endofpacket=eop_pend, out_channel = channel register.
  - sop_pend and eop_pend both clear in the same cycle.
  - SOP and EOP on the same beat is legal (single-byte packet).
- A repeated SOP_CHAR or EOP_CHAR before payload is idempotent.
- A channel change takes effect on the next emitted beat, not on a beat already held in the output register.
- Control bytes never produce an output beat. They are accepted whenever in_ready=1.
- Reset mid-packet discards the held beat, the pending flags and the FSM state. The channel returns to 0.

Optional Feature:
SOC_SYSTEM_B2P_PROTO_ERR_EN
- With the macro: adds output port proto_err (1 bit, reset 0) and an internal in_packet flag (set on a beat with SOP, cleared on a beat with EOP).
- proto_err pulses 1 cycle, aligned with the offending beat loading into the output register, when either:
  - a payload byte has sop_pend=0 and in_packet=0, or
  - a payload byte has sop_pend=1 and in_packet=1.
- The data path is unaffected.
- Without the macro: the port and logic are absent.

Decomposition:
- Package soc_system_b2p_pkg holds the default special-char constants, the FSM state enum (NORMAL/ESC/CHAN/CHAN_ESC, 2-bit) and the ESC_XOR constant 8'h20.
- One sub-module is natural: soc_system_st_out_reg, the single-entry output register with the in_ready = out_ready || !out_valid rule, parameterised on payload width (8+CHANNEL_WIDTH+2).

Test Plan:
- Bytes 7A,7C,05,11,22,7B,33 with out_ready=1:
  - 3 beats: (11,ch5,sop=1,eop=0), (22,ch5,0,0), (33,ch5,0,1).
  - Each beat appears 1 cycle after its byte.
- Bytes 7A,7B,7D,5A: single beat data=7A, sop=1, eop=1.
- Bytes 7C,7D,5C,7A,7B,41: channel=7C (truncated if CHANNEL_WIDTH<8); beat data=41, sop=eop=1.
- out_ready=0 for 5 cycles while a beat is held:
  - in_ready=0 and outputs stable.
  - Releasing out_ready drains the beat and accepts the next byte in the same cycle.
- Assert reset_n=0 mid-packet after 7A,7C,03: all outputs are 0 immediately. After release, byte 44 emits data=44, ch0, sop=0.
- With SOC_SYSTEM_B2P_PROTO_ERR_EN: byte 55 with no prior SOP -> proto_err=1 for one cycle alongside that beat; then 7A,7B,66 -> proto_err=0.
